// File: rtl/float_mul_core_pkg.sv
// Shared definitions for the float multiplier front stage.
// Holds the default widths, the exponent bias and the FSM encodings.
package float_mul_core_pkg;

    localparam int E_DEF = 8;
    localparam int M_DEF = 23;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int calc_bias(input int e);
        return (1 << (e - 1)) - 1;
    endfunction

endpackage

// File: rtl/float_mul_core_seq_mant.sv
// Unsigned WxW radix-2 sequential shift-add multiplier, one step per clock.
// done is high during the final step; product then carries the result that acc takes on that edge.
module float_mul_seq_mant #(
    parameter int W = 24
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] acc_next;
    logic [CW-1:0]  cnt;

    // Accumulator is full double width so no carry is ever dropped.
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign done     = busy && (cnt == LAST);
    assign product  = acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start && !busy) begin
            mcand  <= {{W{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/float_mul_core.sv
// Float multiplier front stage: unpacks operands, forms sign and biased exponent sum,
// and produces the raw unnormalized mantissa product for the normalizer.
module float_mul_core
    import float_mul_core_pkg::*;
#(
    parameter int E = E_DEF,
    parameter int M = M_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [E+M:0]     in_a,
    input  logic [E+M:0]     in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [E:0]       out_exp,
    output logic [2*M+1:0]   out_man
);

    localparam int BIAS = calc_bias(E);

    logic [1:0]     state;
    logic           sa, sb;
    logic [E-1:0]   ea, eb;
    logic [M-1:0]   ma, mb;
    logic [E:0]     exp_sum;
    logic           zero_op;
    logic           accept;
    logic           mul_start, mul_busy, mul_done;
    logic [2*M+1:0] mul_product;

    assign sa = in_a[E+M];
    assign sb = in_b[E+M];
    assign ea = in_a[E+M-1:M];
    assign eb = in_b[E+M-1:M];
    assign ma = in_a[M-1:0];
    assign mb = in_b[M-1:0];

    // Modulo-2^(E+1) arithmetic gives the same low bits as the E+2 bit sum, wrap included.
    assign exp_sum = {1'b0, ea} + {1'b0, eb} - (E+1)'(BIAS);
    assign zero_op = (ea == '0) || (eb == '0);

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_ready && in_valid;
    assign mul_start = accept && !zero_op;

    float_mul_seq_mant #(.W(M + 1)) u_mant (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       ({1'b1, ma}),
        .b       ({1'b1, mb}),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            out_sign <= 1'b0;
            out_exp  <= '0;
            out_man  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        out_sign <= sa ^ sb;
                        if (zero_op) begin
                            // Denormal/zero operands are flushed and skip the multiplier.
                            out_exp <= '0;
                            out_man <= '0;
                            state   <= ST_DONE;
                        end else begin
                            out_exp <= exp_sum;
                            state   <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mul_busy && mul_done) begin
                        out_man <= mul_product;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_mul_core.sv
// Scoreboard bench for float_mul_core with default E=8, M=23.
module tb_float_mul_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [8:0]  out_exp;
    logic [47:0] out_man;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        s;
        logic [8:0]  e;
        logic [47:0] m;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    float_mul_core dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_man   (out_man)
    );

    // Reference model: IEEE single fields, flush on zero exponent.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        logic [47:0] pa, pb;
        logic [9:0]  es;
        r.s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
            r.e = 9'd0;
            r.m = 48'd0;
            r.lat = 1;
        end else begin
            pa = {24'd0, 1'b1, a[22:0]};
            pb = {24'd0, 1'b1, b[22:0]};
            r.m = pa * pb;
            es = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
            r.e = es[8:0];
            r.lat = 25;
        end
        return r;
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input exp_t ex,
                          input int hold, input bit noise);
        int   edges;
        exp_t got;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
        end
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        sb.push_back(ex);
        @(posedge clk);
        edges = 1;
        #1;
        in_valid = 1'b0;
        in_a = $urandom;
        in_b = $urandom;
        while (1) begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
            if (noise) begin
                in_valid = 1'b1;
                in_a = $urandom;
                in_b = $urandom;
            end
            if (edges >= 200) begin
                checks++;
                failures++;
                $display("FAIL timeout: out_valid=%b after %0d edges required within 200", out_valid, edges);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            edges++;
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: output seen with empty queue required an entry");
            in_valid = 1'b0;
            return;
        end
        got = sb.pop_front();
        if (edges !== got.lat) begin
            failures++;
            $display("FAIL latency: edges=%0d required %0d", edges, got.lat);
        end
        checks++;
        if (out_sign !== got.s || out_exp !== got.e || out_man !== got.m) begin
            failures++;
            $display("FAIL result: a=%h b=%h sign=%b exp=%h man=%h required sign=%b exp=%h man=%h",
                     a, b, out_sign, out_exp, out_man, got.s, got.e, got.m);
        end
        for (int i = 0; i < hold; i++) begin
            if (noise) begin
                in_valid = 1'b1;
                in_a = $urandom;
                in_b = $urandom;
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sign !== got.s ||
                out_exp !== got.e || out_man !== got.m) begin
                failures++;
                $display("FAIL hold_stable: cycle=%0d valid=%b ready=%b sign=%b exp=%h man=%h required valid=1 ready=0 sign=%b exp=%h man=%h",
                         i, out_valid, in_ready, out_sign, out_exp, out_man, got.s, got.e, got.m);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL release_idle: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sign !== 1'b0 ||
            out_exp !== 9'd0 || out_man !== 48'd0) begin
            failures++;
            $display("FAIL %s: ready=%b valid=%b sign=%b exp=%h man=%h required 1 0 0 000 000000000000",
                     tag, in_ready, out_valid, out_sign, out_exp, out_man);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_a = '0;
        in_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset_state");
        rst = 1'b0;
    endtask

    task automatic test_directed();
        exp_t ex;
        ex = '{1'b0, 9'h07F, 48'h400000000000, 25};
        run_op(32'h3F800000, 32'h3F800000, ex, 0, 1'b0);
        ex = '{1'b0, 9'h07F, 48'h900000000000, 25};
        run_op(32'h3FC00000, 32'h3FC00000, ex, 0, 1'b0);
        ex = '{1'b1, 9'h081, 48'h600000000000, 25};
        run_op(32'hC0000000, 32'h40400000, ex, 0, 1'b0);
    endtask

    task automatic test_zero_and_wrap();
        exp_t ex;
        ex = '{1'b0, 9'h000, 48'h0, 1};
        run_op(32'h00000000, 32'h40400000, ex, 0, 1'b0);
        ex = '{1'b1, 9'h000, 48'h0, 1};
        run_op(32'h3F800000, 32'h80000000, ex, 0, 1'b0);
        ex = '{1'b0, 9'h183, 48'h400000000000, 25};
        run_op(32'h00800000, 32'h00800000, ex, 0, 1'b0);
        ex = '{1'b0, 9'h17F, 48'hFFFFFE000001, 25};
        run_op(32'h7FFFFFFF, 32'h7FFFFFFF, ex, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        exp_t ex;
        ex = '{1'b1, 9'h081, 48'h600000000000, 25};
        run_op(32'h40400000, 32'hC0000000, ex, 10, 1'b1);
        ex = '{1'b0, 9'h000, 48'h0, 1};
        run_op(32'h40000000, 32'h00123456, ex, 4, 1'b1);
    endtask

    task automatic test_reset_busy();
        exp_t ex;
        @(negedge clk);
        in_a = 32'h3FC00000;
        in_b = 32'h40400000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("reset_in_busy");
        ex = '{1'b0, 9'h07F, 48'h400000000000, 25};
        run_op(32'h3F800000, 32'h3F800000, ex, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom;
            if (i == 5) a[30:23] = 8'd0;
            run_op(a, b, model(a, b), i % 3, i[0]);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_zero_and_wrap();
        test_backpressure();
        test_reset_busy();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: entries=%0d required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
